stage_2_multilane: RTL and testbench
====================================

# stage_2_multilane

Parametrised successor of the encoder's stage 2. It finishes the Q15 CDF interval computation and the one-round normalisation, and chains up to BOOL_LANES 50 %-probability Boolean encodings per cycle. Unlike the purely combinational stage, it owns the range register. It accepts bundles of up to MAX_BOOLS Booleans, serialises them over several cycles, and registers every result behind a valid/ready handshake. It sits between stage 1 (UU/VV/LUT generation) and the carry/low-update stage.

## Interface
Parameters:
- RANGE_WIDTH, 16: range width; low-range results are RANGE_WIDTH+1 bits.
- D_SIZE, 5: normalisation shift width; must hold RANGE_WIDTH.
- SYMBOL_WIDTH, 4: symbol width; only bit 0 is used for Booleans.
- BOOL_LANES, 3: chained Boolean lanes per cycle, 1..8.
- MAX_BOOLS, 6: maximum Booleans per bundle, at least BOOL_LANES.
- CNT_WIDTH, 3: width of the Boolean count; must hold MAX_BOOLS.

Ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_init  in  1  reload range to 2^(RANGE_WIDTH-1).
- in_valid  in  1  bundle present.
- in_ready  out  1  bundle accepted when in_valid && in_ready.
- in_bool_count  in  CNT_WIDTH  0 = CDF operation; otherwise the number of Booleans.
- in_symbols  in  MAX_BOOLS*SYMBOL_WIDTH  symbol k at [k*SYMBOL_WIDTH +: SYMBOL_WIDTH].
- COMP_mux_1, UU, VV, lut_u, lut_v  in  1/RANGE_WIDTH each  CDF operands from stage 1.
- out_valid  out  1  result beat present.
- out_ready  in  1  beat consumed when out_valid && out_ready.
- out_cdf  out  1  beat is a CDF result.
- out_last  out  1  final beat of a bundle.
- out_comp_mux  out  1  registered COMP_mux_1 (CDF beats only, else 0).
- out_lane_valid  out  BOOL_LANES  per-lane valid mask.
- out_symbol  out  BOOL_LANES  per-lane symbol bit 0.
- out_uv  out  BOOL_LANES*(RANGE_WIDTH+1)  per-lane u (CDF) or v (Boolean).
- out_d  out  BOOL_LANES*D_SIZE  per-lane shift count.
- out_initial_range  out  BOOL_LANES*RANGE_WIDTH  per-lane range before encoding.
- out_range  out  RANGE_WIDTH  range after the beat's last valid lane.

## Operation
- State is held in range_q (reset 2^(RANGE_WIDTH-1)), the FSM {IDLE, BOOL_RUN}, the held symbols, remaining count rem_q and lane offset idx_q.
- **Output register advance:** adv = !out_valid || out_ready.
- **Ready:** in_ready = (state==IDLE) && adv && !in_init.
- **in_init:** when sampled high in IDLE, range_q loads 2^(RANGE_WIDTH-1); no bundle is accepted that cycle. In BOOL_RUN it is ignored.
- **Count clamp:** in_bool_count > MAX_BOOLS is clamped to MAX_BOOLS.
- **CDF beat (count 0):**
  - RR = range_q>>8.
  - u = (RR*UU>>1) + lut_u and v = (RR*VV>>1) + lut_v, both RANGE_WIDTH+1 bits.
  - raw = COMP_mux_1 ? u[15:0]-v[15:0] : range_q-v[15:0].
  - d = leading-zero count of raw; raw = 0 gives d = RANGE_WIDTH and range 0, with no recovery.
  - New range = raw<<d. Lane 0 carries u, d and range_q; out_cdf=1, out_last=1.
- **Boolean lane k:** input range r is range_q for k=0, otherwise lane k-1's output.
  - v = ((r>>8)<<7) + 4.
  - raw = sym[0] ? v : r-v.
  - d = 0/1/2/3 by the first set bit among raw[15], [14], [13], or none.
  - Output range = raw<<d.
- **Boolean bundle:**
  - The accept cycle processes lanes 0..min(count,BOOL_LANES)-1 from in_symbols.
  - If Booleans remain, the FSM moves to BOOL_RUN; each cycle with adv high processes the next chunk from the held symbols.
  - The final chunk sets out_last and returns the FSM to IDLE.
- **Lane masking:** invalid lanes drive uv, d and initial_range as 0 and out_symbol 0; out_range = last valid lane's output range.
- **Range update:** range_q is updated on every beat loaded into the output register.

## Timing
- Latency: 1 cycle from accept, or chunk issue, to out_valid.
- A bundle of n Booleans produces ceil(n/BOOL_LANES) beats on consecutive cycles when out_ready stays high.
- Throughput: one CDF per cycle, or BOOL_LANES Booleans per cycle.
- **Backpressure:** when out_valid && !out_ready, all output registers, range_q and the FSM hold.
- **Reset values:** all outputs 0, out_valid=0, in_ready=1 after reset (when in_init=0), FSM IDLE, range_q = 2^(RANGE_WIDTH-1).
- **Reset mid-bundle:** remaining beats are discarded and range_q reinitialises.
- **Simultaneous consume and load:** a beat consumed and the next beat loaded in the same cycle is legal; no bubble is inserted.

## Test plan
- **Bool chain:** reset; bundle count=3, symbols {0,1,0}. Expected beat:
  - lane v = 16388, 32644, 32644
  - d = 2, 1, 1
  - initial_range = 32768, 65520, 65288
  - out_range = 65288, out_last=1, out_lane_valid=3'b111.
- **CDF:** reset; count=0, COMP_mux_1=1, UU=256, VV=128, lut_u=8, lut_v=4. Expected lane 0 u=16392, d=2, out_range=32784, out_cdf=1.
- **Serialisation:** count=4, symbols {0,1,0,0}. Expected:
  - Beat 1 as in the bool-chain test, out_last=0.
  - in_ready=0 during BOOL_RUN.
  - Beat 2: mask 3'b001, initial_range 65288, d=1, out_range 65288, out_last=1.
- **Backpressure:** repeat the serialisation test with out_ready=0 for 3 cycles after beat 1. Expected: beat 1 held stable and range_q unchanged; beat 2 one cycle after release.
- **Reset mid-bundle:** assert reset during BOOL_RUN. Expected out_valid=0 immediately and range_q = 32768; the next bundle encodes from 32768.
- **Init and clamp:** in_init with in_valid high leaves the bundle un-accepted and range = 32768. Count=7 with MAX_BOOLS=6 yields exactly 2 beats.

Source files
------------

// File: rtl/stage_2_multilane.sv
// Encoder stage 2: Q15 CDF interval with one-round normalisation, or up to
// BOOL_LANES chained 50% Boolean encodings per beat. Owns the range register,
// serialises Boolean bundles and registers each beat behind valid/ready.
module stage_2_multilane #(
  parameter int unsigned RANGE_WIDTH  = 16,
  parameter int unsigned D_SIZE       = 5,
  parameter int unsigned SYMBOL_WIDTH = 4,
  parameter int unsigned BOOL_LANES   = 3,
  parameter int unsigned MAX_BOOLS    = 6,
  parameter int unsigned CNT_WIDTH    = 3
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       in_init,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [CNT_WIDTH-1:0]                       in_bool_count,
  input  logic [MAX_BOOLS*SYMBOL_WIDTH-1:0]          in_symbols,
  input  logic                                       COMP_mux_1,
  input  logic [RANGE_WIDTH-1:0]                     UU,
  input  logic [RANGE_WIDTH-1:0]                     VV,
  input  logic [RANGE_WIDTH-1:0]                     lut_u,
  input  logic [RANGE_WIDTH-1:0]                     lut_v,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       out_cdf,
  output logic                                       out_last,
  output logic                                       out_comp_mux,
  output logic [BOOL_LANES-1:0]                      out_lane_valid,
  output logic [BOOL_LANES-1:0]                      out_symbol,
  output logic [BOOL_LANES*(RANGE_WIDTH+1)-1:0]      out_uv,
  output logic [BOOL_LANES*D_SIZE-1:0]               out_d,
  output logic [BOOL_LANES*RANGE_WIDTH-1:0]          out_initial_range,
  output logic [RANGE_WIDTH-1:0]                     out_range
);

  localparam int unsigned RW  = RANGE_WIDTH;
  localparam int unsigned UVW = RANGE_WIDTH + 1;
  localparam int unsigned PW  = 2 * RANGE_WIDTH;
  localparam int unsigned SW  = MAX_BOOLS * SYMBOL_WIDTH;
  localparam int unsigned UVL = BOOL_LANES * UVW;
  localparam int unsigned DL  = BOOL_LANES * D_SIZE;
  localparam int unsigned IRL = BOOL_LANES * RW;
  localparam logic [RW-1:0]        RANGE_INIT = RW'(1) << (RW - 1);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT    = CNT_WIDTH'(MAX_BOOLS);
  localparam logic [CNT_WIDTH-1:0] LANES_CNT  = CNT_WIDTH'(BOOL_LANES);

  typedef enum logic {IDLE, BOOL_RUN} state_t;

  state_t               state_q;
  logic [RW-1:0]        range_q;
  logic [SW-1:0]        syms_q;
  logic [CNT_WIDTH-1:0] rem_q;
  logic [CNT_WIDTH-1:0] idx_q;

  logic                 adv, accept, load, is_cdf, cdf_beat;
  logic [CNT_WIDTH-1:0] cnt_cl, chunk_cnt, chunk_n, chunk_base;
  logic [SW-1:0]        chunk_syms;
  logic [UVW-1:0]       c_u;
  logic [RW-1:0]        c_vlo, c_raw, c_range;
  logic [D_SIZE-1:0]    c_d;
  logic [BOOL_LANES-1:0] b_lane_valid, b_sym;
  logic [UVL-1:0]       b_uv;
  logic [DL-1:0]        b_d;
  logic [IRL-1:0]       b_ir;
  logic [RW-1:0]        b_range;

  // Leading-zero count; all-zero input yields RANGE_WIDTH.
  function automatic logic [D_SIZE-1:0] lzc(input logic [RANGE_WIDTH-1:0] x);
    logic [D_SIZE-1:0] n;
    n = D_SIZE'(RANGE_WIDTH);
    for (int unsigned i = 0; i < RANGE_WIDTH; i++)
      if (x[i]) n = D_SIZE'(RANGE_WIDTH - 1 - i);
    return n;
  endfunction

  // Handshake, count clamp and selection of the chunk to issue this cycle.
  always_comb begin
    adv        = !out_valid || out_ready;
    in_ready   = (state_q == IDLE) && adv && !in_init;
    accept     = in_valid && in_ready;
    load       = adv && (accept || (state_q == BOOL_RUN));
    cnt_cl     = (in_bool_count > MAX_CNT) ? MAX_CNT : in_bool_count;
    is_cdf     = (cnt_cl == '0);
    cdf_beat   = (state_q == IDLE) && is_cdf;
    chunk_syms = (state_q == IDLE) ? in_symbols : syms_q;
    chunk_base = (state_q == IDLE) ? '0 : idx_q;
    chunk_cnt  = (state_q == IDLE) ? cnt_cl : rem_q;
    chunk_n    = (chunk_cnt > LANES_CNT) ? LANES_CNT : chunk_cnt;
  end

  // CDF interval and single-round normalisation.
  always_comb begin
    c_u     = UVW'((PW'(range_q >> 8) * PW'(UU)) >> 1) + UVW'(lut_u);
    c_vlo   = RW'((PW'(range_q >> 8) * PW'(VV)) >> 1) + lut_v;
    c_raw   = COMP_mux_1 ? (c_u[RW-1:0] - c_vlo) : (range_q - c_vlo);
    c_d     = lzc(c_raw);
    c_range = c_raw << c_d;
  end

  // Chained Boolean lanes; each valid lane feeds its range to the next.
  always_comb begin
    logic [RW-1:0]     r, v, raw;
    logic [D_SIZE-1:0] d;
    logic [SW-1:0]     shifted;
    int unsigned       pos;
    r = range_q;
    v = '0;
    raw = '0;
    d = '0;
    shifted = '0;
    pos = 0;
    b_lane_valid = '0;
    b_sym = '0;
    b_uv = '0;
    b_d = '0;
    b_ir = '0;
    for (int unsigned k = 0; k < BOOL_LANES; k++) begin
      pos     = 32'(chunk_base) + k;
      shifted = chunk_syms >> (pos * SYMBOL_WIDTH);
      v       = ((r >> 8) << 7) + RW'(4);
      raw     = shifted[0] ? v : (r - v);
      if (raw[RW-1])      d = D_SIZE'(0);
      else if (raw[RW-2]) d = D_SIZE'(1);
      else if (raw[RW-3]) d = D_SIZE'(2);
      else                d = D_SIZE'(3);
      if (k < 32'(chunk_n)) begin
        b_lane_valid[k]          = 1'b1;
        b_sym[k]                 = shifted[0];
        b_uv[k*UVW +: UVW]       = {1'b0, v};
        b_d[k*D_SIZE +: D_SIZE]  = d;
        b_ir[k*RW +: RW]         = r;
        r                        = raw << d;
      end
    end
    b_range = r;
  end

  // Output beat, range, FSM and serialisation state; all hold while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      range_q           <= RANGE_INIT;
      syms_q            <= '0;
      rem_q             <= '0;
      idx_q             <= '0;
      out_valid         <= 1'b0;
      out_cdf           <= 1'b0;
      out_last          <= 1'b0;
      out_comp_mux      <= 1'b0;
      out_lane_valid    <= '0;
      out_symbol        <= '0;
      out_uv            <= '0;
      out_d             <= '0;
      out_initial_range <= '0;
      out_range         <= '0;
    end else if (adv) begin
      out_valid <= load;
      if (load) begin
        out_cdf           <= cdf_beat;
        out_last          <= (chunk_cnt <= LANES_CNT);
        out_comp_mux      <= cdf_beat && COMP_mux_1;
        out_lane_valid    <= cdf_beat ? BOOL_LANES'(1) : b_lane_valid;
        out_symbol        <= cdf_beat ? '0 : b_sym;
        out_uv            <= cdf_beat ? UVL'(c_u) : b_uv;
        out_d             <= cdf_beat ? DL'(c_d) : b_d;
        out_initial_range <= cdf_beat ? IRL'(range_q) : b_ir;
        out_range         <= cdf_beat ? c_range : b_range;
        range_q           <= cdf_beat ? c_range : b_range;
      end
      if (state_q == IDLE) begin
        if (in_init) range_q <= RANGE_INIT;
        if (accept && !is_cdf) begin
          syms_q <= in_symbols;
          if (cnt_cl > LANES_CNT) begin
            state_q <= BOOL_RUN;
            rem_q   <= cnt_cl - LANES_CNT;
            idx_q   <= LANES_CNT;
          end
        end
      end else begin
        rem_q <= rem_q - chunk_n;
        idx_q <= idx_q + chunk_n;
        if (rem_q <= LANES_CNT) state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_stage_2_multilane.sv
// Bench for stage_2_multilane: directed scenarios plus random bundles with
// random output stalls, checked beat by beat against an arithmetic model.
module tb_stage_2_multilane;

  localparam int RW  = 16;
  localparam int DS  = 5;
  localparam int SWD = 4;
  localparam int BL  = 3;
  localparam int MB  = 6;
  localparam int CW  = 3;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_init;
  logic                    in_valid;
  logic                    in_ready;
  logic [CW-1:0]           in_bool_count;
  logic [MB*SWD-1:0]       in_symbols;
  logic                    COMP_mux_1;
  logic [RW-1:0]           UU, VV, lut_u, lut_v;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_cdf;
  logic                    out_last;
  logic                    out_comp_mux;
  logic [BL-1:0]           out_lane_valid;
  logic [BL-1:0]           out_symbol;
  logic [BL*(RW+1)-1:0]    out_uv;
  logic [BL*DS-1:0]        out_d;
  logic [BL*RW-1:0]        out_initial_range;
  logic [RW-1:0]           out_range;

  always #5 clk = ~clk;

  stage_2_multilane dut (
    .clk(clk), .reset(reset), .in_init(in_init), .in_valid(in_valid),
    .in_ready(in_ready), .in_bool_count(in_bool_count), .in_symbols(in_symbols),
    .COMP_mux_1(COMP_mux_1), .UU(UU), .VV(VV), .lut_u(lut_u), .lut_v(lut_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_cdf(out_cdf),
    .out_last(out_last), .out_comp_mux(out_comp_mux),
    .out_lane_valid(out_lane_valid), .out_symbol(out_symbol), .out_uv(out_uv),
    .out_d(out_d), .out_initial_range(out_initial_range), .out_range(out_range)
  );

  typedef struct {
    bit                 cdf;
    bit                 last;
    bit                 cm;
    bit [BL-1:0]        lv;
    bit [BL-1:0]        sym;
    bit [BL*(RW+1)-1:0] uv;
    bit [BL*DS-1:0]     d;
    bit [BL*RW-1:0]     ir;
    bit [RW-1:0]        rng;
  } beat_t;

  beat_t         exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            model_range = 32768;
  int            rdy_mode = 0;
  int            consumed = 0;
  bit            accepted = 1'b0;
  logic [RW-1:0] last_range = '0;
  logic [RW:0]   last_uv0 = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lzc(input int x);
    for (int b = RW - 1; b >= 0; b--)
      if (((x >> b) & 1) == 1) return RW - 1 - b;
    return RW;
  endfunction

  // Expected beats of one accepted bundle, from the current model range.
  task automatic model_push(input int cnt, input logic [MB*SWD-1:0] syms, input bit cm,
                            input int uu, input int vv, input int lu, input int lv);
    beat_t b;
    int n, r, u, v, raw, d, pos;
    logic [MB*SWD-1:0] sh;
    n = (cnt > MB) ? MB : cnt;
    r = model_range;
    if (n == 0) begin
      u   = (((r / 256) * uu) / 2 + lu) % 131072;
      v   = (((r / 256) * vv) / 2 + lv) % 131072;
      raw = cm ? ((u - v) & 65535) : ((r - v) & 65535);
      d   = lzc(raw);
      b = '{default: 0};
      b.cdf = 1'b1; b.last = 1'b1; b.cm = cm; b.lv = 3'b001;
      b.uv[RW:0] = 17'(u);
      b.d[DS-1:0] = 5'(d);
      b.ir[RW-1:0] = 16'(r);
      r = (raw << d) & 65535;
      b.rng = 16'(r);
      exp_q.push_back(b);
    end else begin
      pos = 0;
      while (pos < n) begin
        b = '{default: 0};
        for (int k = 0; k < BL && pos < n; k++) begin
          sh  = syms >> (pos * SWD);
          v   = (r / 256) * 128 + 4;
          raw = sh[0] ? v : ((r - v) & 65535);
          d   = (raw >= 32768) ? 0 : (raw >= 16384) ? 1 : (raw >= 8192) ? 2 : 3;
          b.lv[k] = 1'b1;
          b.sym[k] = sh[0];
          b.uv[k*(RW+1) +: (RW+1)] = 17'(v);
          b.d[k*DS +: DS] = 5'(d);
          b.ir[k*RW +: RW] = 16'(r);
          r = (raw << d) & 65535;
          pos++;
        end
        b.rng = 16'(r);
        b.last = (pos == n);
        exp_q.push_back(b);
      end
    end
    model_range = r;
  endtask

  // One clock: sample both handshakes before the edge, then advance.
  task automatic cycle();
    bit    hs_in, hs_out;
    beat_t e;
    #1;
    hs_out = out_valid && out_ready;
    hs_in  = in_valid && in_ready;
    if (hs_out) begin
      consumed++;
      if (exp_q.size() == 0) begin
        chk("spurious_beat", 64'(out_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("cdf", 64'(out_cdf), 64'(e.cdf));
        chk("last", 64'(out_last), 64'(e.last));
        chk("comp_mux", 64'(out_comp_mux), 64'(e.cm));
        chk("lane_valid", 64'(out_lane_valid), 64'(e.lv));
        chk("symbol", 64'(out_symbol), 64'(e.sym));
        chk("uv", 64'(out_uv), 64'(e.uv));
        chk("d", 64'(out_d), 64'(e.d));
        chk("init_range", 64'(out_initial_range), 64'(e.ir));
        chk("range", 64'(out_range), 64'(e.rng));
      end
      last_range = out_range;
      last_uv0   = out_uv[RW:0];
    end
    if (hs_in)
      model_push(int'(in_bool_count), in_symbols, COMP_mux_1, int'(UU), int'(VV),
                 int'(lut_u), int'(lut_v));
    @(negedge clk);
    if (hs_in) begin
      in_valid = 1'b0;
      accepted = 1'b1;
    end
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(3) != 0);
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic send(input int cnt, input logic [MB*SWD-1:0] syms, input bit cm,
                      input int uu, input int vv, input int lu, input int lv);
    in_bool_count = 3'(cnt);
    in_symbols    = syms;
    COMP_mux_1    = cm;
    UU            = 16'(uu);
    VV            = 16'(vv);
    lut_u         = 16'(lu);
    lut_v         = 16'(lv);
    in_valid      = 1'b1;
    accepted      = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) cycle();
    if (!accepted) begin
      chk("accept_timeout", 64'(accepted), 64'(1));
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || out_valid); i++) cycle();
    chk("drain_left", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_init = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    model_range = 32768;
  endtask

  logic [BL*(RW+1)-1:0] snap_uv;
  logic [RW-1:0]        snap_rng;
  int                   c0;

  initial begin
    reset = 1'b1; in_init = 1'b0; in_valid = 1'b0; in_bool_count = '0;
    in_symbols = '0; COMP_mux_1 = 1'b0; UU = '0; VV = '0; lut_u = '0; lut_v = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_range", 64'(out_range), 64'(0));
    chk("rst_out_uv", 64'(out_uv), 64'(0));
    reset = 1'b0;

    // Bool chain {0,1,0} from 32768
    send(3, 24'h000010, 1'b0, 0, 0, 0, 0);
    drain();
    chk("chain_range", 64'(last_range), 64'(65288));
    chk("chain_uv0", 64'(last_uv0), 64'(16388));

    // CDF beat
    do_reset();
    send(0, 24'h0, 1'b1, 256, 128, 8, 4);
    drain();
    chk("cdf_u", 64'(last_uv0), 64'(16392));
    chk("cdf_range", 64'(last_range), 64'(32784));

    // Serialisation of four Booleans
    do_reset();
    send(4, 24'h000010, 1'b0, 0, 0, 0, 0);
    #1;
    chk("run_in_ready", 64'(in_ready), 64'(0));
    drain();
    chk("ser_range", 64'(last_range), 64'(65288));

    // Backpressure after beat 1
    do_reset();
    rdy_mode = 2;
    out_ready = 1'b0;
    send(4, 24'h000010, 1'b0, 0, 0, 0, 0);
    snap_uv = out_uv;
    snap_rng = out_range;
    chk("bp_valid", 64'(out_valid), 64'(1));
    repeat (3) begin
      cycle();
      chk("bp_hold_uv", 64'(out_uv), 64'(snap_uv));
      chk("bp_hold_rng", 64'(out_range), 64'(snap_rng));
    end
    rdy_mode = 0;
    out_ready = 1'b1;
    cycle();
    chk("bp_beat2_valid", 64'(out_valid), 64'(1));
    chk("bp_beat2_last", 64'(out_last), 64'(1));
    drain();

    // Reset in the middle of a bundle
    do_reset();
    send(6, 24'h123456, 1'b0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    exp_q.delete();
    model_range = 32768;
    @(negedge clk);
    reset = 1'b0;
    send(3, 24'h000010, 1'b0, 0, 0, 0, 0);
    drain();
    chk("midrst_uv0", 64'(last_uv0), 64'(16388));

    // Init blocks acceptance and reloads the range
    in_bool_count = 3'd3; in_symbols = 24'h000010; in_init = 1'b1; in_valid = 1'b1;
    #1;
    chk("init_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    in_init = 1'b0;
    model_range = 32768;
    send(3, 24'h000010, 1'b0, 0, 0, 0, 0);
    drain();
    chk("init_uv0", 64'(last_uv0), 64'(16388));
    chk("init_range", 64'(last_range), 64'(65288));

    // Count clamp: 7 becomes 6, i.e. two beats
    c0 = consumed;
    send(7, 24'hABCDEF, 1'b0, 0, 0, 0, 0);
    drain();
    chk("clamp_beats", 64'(consumed - c0), 64'(2));

    // Random bundles with random stalls and occasional init
    rdy_mode = 1;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(19) == 0) begin
        drain();
        in_init = 1'b1;
        @(negedge clk);
        in_init = 1'b0;
        model_range = 32768;
      end else begin
        send(int'($urandom_range(7)), 24'($urandom), 1'($urandom_range(1)),
             int'($urandom_range(65535)), int'($urandom_range(65535)),
             int'($urandom_range(65535)), int'($urandom_range(65535)));
      end
      if ($urandom_range(3) == 0) repeat ($urandom_range(3)) cycle();
    end
    rdy_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
